// File: rtl/rf_riscv_mp.sv
// Multi-port integer register file: NRD combinational read ports, two write ports (W1 wins on
// collision), register 0 hardwired to zero, and a post-reset sequential clear sweep gating ready_o.
module rf_riscv_mp #(
    parameter  int unsigned XLEN   = 32,
    parameter  int unsigned DEPTH  = 32,
    parameter  int unsigned NRD    = 2,
    parameter  int unsigned BYPASS = 0,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  ready_o,
    input  logic [NRD*AW-1:0]     read_addr_i,
    output logic [NRD*XLEN-1:0]   read_data_o,
    input  logic                  we0_i,
    input  logic [AW-1:0]         wa0_i,
    input  logic [XLEN-1:0]       wd0_i,
    input  logic                  we1_i,
    input  logic [AW-1:0]         wa1_i,
    input  logic [XLEN-1:0]       wd1_i,
    output logic                  wr_conflict_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            ready_q, ready_d;
    logic            conflict_q, conflict_d;
    logic            clr_we_c;
    logic            wr0_en_c;
    logic            wr1_en_c;

    logic [XLEN-1:0] mem_q [DEPTH];

    // State register; reset always restarts the clear sweep at address 1
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= AW'(1);
            ready_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            ready_q    <= ready_d;
            conflict_q <= conflict_d;
        end
    end

    // Next-state logic and write qualification
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        ready_d    = ready_q;
        conflict_d = 1'b0;
        clr_we_c   = 1'b0;
        wr0_en_c   = 1'b0;
        wr1_en_c   = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_we_c  = 1'b1;
                clr_cnt_d = AW'(clr_cnt_q + 1'b1);
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                wr0_en_c   = we0_i && (wa0_i != '0);
                wr1_en_c   = we1_i && (wa1_i != '0);
                conflict_d = wr0_en_c && wr1_en_c && (wa0_i == wa1_i);
            end
        endcase
    end

    // Storage array; W1 is written last so it overrides W0 on a shared address
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (clr_we_c) begin
                mem_q[clr_cnt_q] <= '0;
            end
            if (wr0_en_c) begin
                mem_q[wa0_i] <= wd0_i;
            end
            if (wr1_en_c) begin
                mem_q[wa1_i] <= wd1_i;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   raddr;
        logic [XLEN-1:0] rdata;

        assign raddr = read_addr_i[k*AW +: AW];

        // Zero-latency read with optional same-cycle forwarding; lanes are blanked while clearing
        always_comb begin
            rdata = mem_q[raddr];
            if (BYPASS != 0) begin
                if (wr0_en_c && (wa0_i == raddr)) begin
                    rdata = wd0_i;
                end
                if (wr1_en_c && (wa1_i == raddr)) begin
                    rdata = wd1_i;
                end
            end
            if ((state_q != RUN) || (raddr == '0)) begin
                rdata = '0;
            end
        end

        assign read_data_o[k*XLEN +: XLEN] = rdata;
    end

    assign ready_o       = ready_q;
    assign wr_conflict_o = conflict_q;

endmodule

// File: tb/tb_rf_riscv_mp.sv
// Bench for rf_riscv_mp: a BYPASS=0 and a BYPASS=1 instance (NRD=4) share stimulus and are
// checked against constant vectors, hand sequences, and a behavioural model under random traffic.
module tb_rf_riscv_mp;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NRD   = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   ra;
    logic                we0, we1;
    logic [AW-1:0]       wa0, wa1;
    logic [XLEN-1:0]     wd0, wd1;
    logic                rdy0, rdy1, cf0, cf1;
    logic [NRD*XLEN-1:0] rd0, rd1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_riscv_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD), .BYPASS(0)) dut_nb (
        .clk_i(clk), .rst_i(rst), .ready_o(rdy0), .read_addr_i(ra), .read_data_o(rd0),
        .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0), .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
        .wr_conflict_o(cf0)
    );

    rf_riscv_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD), .BYPASS(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .ready_o(rdy1), .read_addr_i(ra), .read_data_o(rd1),
        .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0), .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
        .wr_conflict_o(cf1)
    );

    // Reference model: register contents, clearing progress, pending conflict flag
    logic [XLEN-1:0] mem_m [DEPTH];
    bit              run_m  = 1'b0;
    bit              conf_m = 1'b0;
    int              pos_m  = 1;

    always @(posedge clk) begin
        if (rst) begin
            run_m  <= 1'b0;
            pos_m  <= 1;
            conf_m <= 1'b0;
        end else if (!run_m) begin
            mem_m[pos_m] <= '0;
            pos_m        <= pos_m + 1;
            if (pos_m == DEPTH - 1) run_m <= 1'b1;
            conf_m <= 1'b0;
        end else begin
            conf_m <= we0 && we1 && (wa0 == wa1) && (wa0 != 0);
            if (we0 && wa0 != 0) mem_m[wa0] <= wd0;
            if (we1 && wa1 != 0) mem_m[wa1] <= wd1;
        end
    end

    function automatic logic [XLEN-1:0] exp_lane(input bit byp, input logic [AW-1:0] a);
        if (!run_m || a == 0) return '0;
        if (byp && we1 && wa1 == a) return wd1;
        if (byp && we0 && wa0 == a) return wd0;
        return mem_m[a];
    endfunction

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_lanes(input string tag, input logic [NRD*XLEN-1:0] act,
                             input logic [NRD*XLEN-1:0] exp);
        for (int k = 0; k < NRD; k++)
            chk($sformatf("%s_lane%0d", tag, k), act[k*XLEN +: XLEN], exp[k*XLEN +: XLEN]);
    endtask

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
    endtask

    task automatic pulse_reset();
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts sampled cycles with ready low; optionally hammers both write ports meanwhile
    task automatic wait_ready(input bit noise, output int c0, output int c1);
        bit done;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 100; i++) begin
            if (noise) begin
                we0 = 1'b1; wa0 = AW'(i);     wd0 = $urandom;
                we1 = 1'b1; wa1 = AW'(i + 7); wd1 = $urandom;
            end
            #1;
            if (!rdy0) c0++;
            if (!rdy1) c1++;
            done = rdy0 && rdy1;
            if (done) idle();
            @(negedge clk);
            if (done) break;
        end
    endtask

    typedef struct {
        logic            we0;
        logic [AW-1:0]   wa0;
        logic [XLEN-1:0] wd0;
        logic            we1;
        logic [AW-1:0]   wa1;
        logic [XLEN-1:0] wd1;
        logic [NRD*AW-1:0]   ra;
        logic [NRD*XLEN-1:0] exp_nb;
        logic [NRD*XLEN-1:0] exp_b;
        logic            conf;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int c0, c1;

        tbl[0] = '{1, 5'd3,  32'h12345678, 0, 5'd0, 32'h0, {5'd3, 5'd0, 5'd9, 5'd3},
                   {32'h0, 32'h0, 32'h0, 32'h0},
                   {32'h12345678, 32'h0, 32'h0, 32'h12345678}, 0};
        tbl[1] = '{0, 5'd0,  32'h0, 1, 5'd0, 32'hFFFFFFFF, {5'd0, 5'd3, 5'd0, 5'd3},
                   {32'h0, 32'h12345678, 32'h0, 32'h12345678},
                   {32'h0, 32'h12345678, 32'h0, 32'h12345678}, 0};
        tbl[2] = '{1, 5'd7,  32'hAAAA, 1, 5'd7, 32'h5555, {5'd0, 5'd3, 5'd7, 5'd7},
                   {32'h0, 32'h12345678, 32'h0, 32'h0},
                   {32'h0, 32'h12345678, 32'h5555, 32'h5555}, 0};
        tbl[3] = '{1, 5'd0,  32'h1, 1, 5'd0, 32'h2, {5'd0, 5'd0, 5'd0, 5'd7},
                   {32'h0, 32'h0, 32'h0, 32'h5555},
                   {32'h0, 32'h0, 32'h0, 32'h5555}, 1};
        tbl[4] = '{0, 5'd0,  32'h0, 0, 5'd0, 32'h0, {5'd7, 5'd7, 5'd7, 5'd7},
                   {32'h5555, 32'h5555, 32'h5555, 32'h5555},
                   {32'h5555, 32'h5555, 32'h5555, 32'h5555}, 0};
        tbl[5] = '{1, 5'd9,  32'h77, 0, 5'd0, 32'h0, {5'd0, 5'd0, 5'd9, 5'd9},
                   {32'h0, 32'h0, 32'h0, 32'h0},
                   {32'h0, 32'h0, 32'h77, 32'h77}, 0};
        tbl[6] = '{1, 5'd12, 32'hCAFE, 0, 5'd0, 32'h0, {5'd9, 5'd9, 5'd9, 5'd9},
                   {32'h77, 32'h77, 32'h77, 32'h77},
                   {32'h77, 32'h77, 32'h77, 32'h77}, 0};
        tbl[7] = '{0, 5'd0,  32'h0, 0, 5'd0, 32'h0, {5'd12, 5'd12, 5'd12, 5'd12},
                   {32'hCAFE, 32'hCAFE, 32'hCAFE, 32'hCAFE},
                   {32'hCAFE, 32'hCAFE, 32'hCAFE, 32'hCAFE}, 0};
        tbl[8] = '{1, 5'd4,  32'h44, 1, 5'd5, 32'h55, {5'd5, 5'd4, 5'd12, 5'd0},
                   {32'h0, 32'h0, 32'hCAFE, 32'h0},
                   {32'h55, 32'h44, 32'hCAFE, 32'h0}, 0};
        tbl[9] = '{0, 5'd0,  32'h0, 0, 5'd0, 32'h0, {5'd5, 5'd4, 5'd12, 5'd0},
                   {32'h55, 32'h44, 32'hCAFE, 32'h0},
                   {32'h55, 32'h44, 32'hCAFE, 32'h0}, 0};

        // Power-up reset: outputs quiet, lanes forced to zero
        idle();
        rst = 1'b1;
        ra  = {5'd4, 5'd3, 5'd2, 5'd1};
        @(negedge clk);
        #1;
        chk("reset_ready_nb", 32'(rdy0), 32'h0);
        chk("reset_ready_b",  32'(rdy1), 32'h0);
        chk("reset_conf_nb",  32'(cf0),  32'h0);
        chk("reset_conf_b",   32'(cf1),  32'h0);
        chk_lanes("reset_nb", rd0, '0);
        chk_lanes("reset_b",  rd1, '0);
        rst = 1'b0;
        wait_ready(1'b0, c0, c1);
        chk("init_clear_len_nb", 32'(c0), 32'd31);
        chk("init_clear_len_b",  32'(c1), 32'd31);

        // Preloaded value is wiped by a later reset; ready low for DEPTH-1 cycles
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD;
        @(negedge clk);
        idle();
        ra = {5'd0, 5'd0, 5'd0, 5'd5};
        #1;
        chk("preload_nb", rd0[XLEN-1:0], 32'hDEAD);
        chk("preload_b",  rd1[XLEN-1:0], 32'hDEAD);
        @(negedge clk);
        pulse_reset();
        wait_ready(1'b0, c0, c1);
        chk("clear_len_nb", 32'(c0), 32'd31);
        chk("clear_len_b",  32'(c1), 32'd31);
        #1;
        chk("cleared5_nb", rd0[XLEN-1:0], 32'h0);
        chk("cleared5_b",  rd1[XLEN-1:0], 32'h0);
        @(negedge clk);

        // Directed vectors in RUN
        for (int i = 0; i < 10; i++) begin
            we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
            we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
            ra  = tbl[i].ra;
            #1;
            chk($sformatf("vec%0d_conf_nb", i), 32'(cf0), 32'(tbl[i].conf));
            chk($sformatf("vec%0d_conf_b", i),  32'(cf1), 32'(tbl[i].conf));
            chk_lanes($sformatf("vec%0d_nb", i), rd0, tbl[i].exp_nb);
            chk_lanes($sformatf("vec%0d_b", i),  rd1, tbl[i].exp_b);
            @(negedge clk);
        end
        idle();

        // Reset mid-clear restarts the sweep; writes during clear are dropped
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            we0 = 1'b1; wa0 = AW'(i + 20); wd0 = $urandom;
            we1 = 1'b1; wa1 = AW'(i + 3);  wd1 = $urandom;
            #1;
            chk($sformatf("clr_ready_nb%0d", i), 32'(rdy0), 32'h0);
            @(negedge clk);
        end
        pulse_reset();
        wait_ready(1'b1, c0, c1);
        chk("reclear_len_nb", 32'(c0), 32'd31);
        chk("reclear_len_b",  32'(c1), 32'd31);
        for (int j = 0; j < DEPTH / NRD; j++) begin
            ra = {AW'(4*j + 3), AW'(4*j + 2), AW'(4*j + 1), AW'(4*j)};
            #1;
            chk_lanes($sformatf("swept%0d_nb", j), rd0, '0);
            chk_lanes($sformatf("swept%0d_b", j),  rd1, '0);
            @(negedge clk);
        end

        // Random traffic against the model, with occasional resets
        for (int n = 0; n < 10000; n++) begin
            rst = ($urandom_range(0, 599) == 0);
            we0 = $urandom_range(0, 1);
            we1 = $urandom_range(0, 1);
            wa0 = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wa1 = ($urandom_range(0, 2) == 0) ? wa0 : AW'($urandom);
            wd0 = $urandom;
            wd1 = $urandom;
            for (int k = 0; k < NRD; k++) begin
                case ($urandom_range(0, 3))
                    0:       ra[k*AW +: AW] = wa0;
                    1:       ra[k*AW +: AW] = wa1;
                    default: ra[k*AW +: AW] = AW'($urandom);
                endcase
            end
            #1;
            chk("rnd_ready_nb", 32'(rdy0), 32'(run_m));
            chk("rnd_ready_b",  32'(rdy1), 32'(run_m));
            chk("rnd_conf_nb",  32'(cf0),  32'(conf_m));
            chk("rnd_conf_b",   32'(cf1),  32'(conf_m));
            for (int k = 0; k < NRD; k++) begin
                chk($sformatf("rnd%0d_nb_lane%0d", n, k), rd0[k*XLEN +: XLEN],
                    exp_lane(1'b0, ra[k*AW +: AW]));
                chk($sformatf("rnd%0d_b_lane%0d", n, k),  rd1[k*XLEN +: XLEN],
                    exp_lane(1'b1, ra[k*AW +: AW]));
            end
            @(negedge clk);
        end
        rst = 1'b0;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
